// File: rtl/mem_stage_mc.sv
// Memory pipeline stage: issues req/done accesses to a variable-latency data memory,
// stalls upstream while busy, and selects the register write-back data.
module mem_stage_mc #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_mem_en,
  input  logic              in_mem_wr,
  input  logic              in_byte,
  input  logic              in_halt,
  input  logic              in_reg_wrt,
  input  logic [2:0]        in_wrt_src,
  input  logic [REG_W-1:0]  in_write_reg,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic [DATA_W-1:0] in_set_val,
  input  logic [DATA_W-1:0] in_reg1,
  input  logic [DATA_W-1:0] in_reg2,
  input  logic [DATA_W-1:0] in_next_pc,
  input  logic [DATA_W-1:0] in_instr,
  output logic [DATA_W-1:0] fwd_data,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_wr,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err,
  output logic              mem_dump,
  output logic              wb_valid,
  output logic              wb_reg_wrt,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_err,
  output logic              wb_halt
);

  typedef enum logic [1:0] {IDLE, BUSY, HALTED} state_t;
  state_t state_q, state_d;

  logic              src_err;
  logic [DATA_W-1:0] byte_wdata;
  logic              unused_instr;

  // request and pending write-back context, latched when an access has to wait
  logic              p_wr_q, p_wr_d, p_byte_q, p_byte_d, p_byte_hi_q, p_byte_hi_d;
  logic              p_src_zero_q, p_src_zero_d, p_src_err_q, p_src_err_d;
  logic              p_halt_q, p_halt_d, p_reg_wrt_q, p_reg_wrt_d;
  logic [REG_W-1:0]  p_write_reg_q, p_write_reg_d;
  logic [ADDR_W-1:0] p_addr_q, p_addr_d;
  logic [DATA_W-1:0] p_wdata_q, p_wdata_d, p_src_val_q, p_src_val_d;

  logic              wb_valid_q, wb_valid_d, wb_reg_wrt_q, wb_reg_wrt_d;
  logic              wb_err_q, wb_err_d, wb_halt_q, wb_halt_d, mem_dump_q, mem_dump_d;
  logic [REG_W-1:0]  wb_write_reg_q, wb_write_reg_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic              complete, c_mem, c_wr, c_byte, c_byte_hi, c_src_zero, c_src_err;
  logic              c_misalign, c_halt, c_reg_wrt, c_err;
  logic [REG_W-1:0]  c_write_reg;
  logic [DATA_W-1:0] c_src_val, c_load_val;

  assign unused_instr = ^in_instr[DATA_W-1:8];

  always_comb begin
    fwd_data = '0;
    src_err  = 1'b0;
    case (in_wrt_src)
      3'd1: fwd_data = in_alu_out;
      3'd2: fwd_data = in_next_pc;
      3'd3: fwd_data = in_set_val;
      3'd4: fwd_data = {{(DATA_W-8){in_instr[7]}}, in_instr[7:0]};
      3'd5: fwd_data = {in_reg1[DATA_W-9:0], in_instr[7:0]};
      3'd6: for (int i = 0; i < DATA_W; i++) fwd_data[i] = in_reg1[DATA_W-1-i];
      3'd7: src_err = 1'b1;
      default: fwd_data = '0;
    endcase
  end

  // byte stores replicate the low byte of reg2 across every lane
  always_comb begin
    byte_wdata = '0;
    for (int i = 0; i < DATA_W; i++) byte_wdata[i] = in_reg2[i % 8];
  end

  always_comb begin
    state_d        = state_q;
    p_wr_d         = p_wr_q;
    p_byte_d       = p_byte_q;
    p_byte_hi_d    = p_byte_hi_q;
    p_src_zero_d   = p_src_zero_q;
    p_src_err_d    = p_src_err_q;
    p_halt_d       = p_halt_q;
    p_reg_wrt_d    = p_reg_wrt_q;
    p_write_reg_d  = p_write_reg_q;
    p_addr_d       = p_addr_q;
    p_wdata_d      = p_wdata_q;
    p_src_val_d    = p_src_val_q;
    wb_valid_d     = 1'b0;
    wb_reg_wrt_d   = 1'b0;
    wb_write_reg_d = wb_write_reg_q;
    wb_data_d      = wb_data_q;
    wb_err_d       = wb_err_q;
    wb_halt_d      = wb_halt_q;
    mem_dump_d     = 1'b0;
    mem_req        = 1'b0;
    mem_wr         = 1'b0;
    mem_byte       = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    stall_out      = 1'b0;
    complete       = 1'b0;
    c_mem          = 1'b0;
    c_wr           = 1'b0;
    c_byte         = 1'b0;
    c_byte_hi      = 1'b0;
    c_src_zero     = 1'b0;
    c_src_err      = 1'b0;
    c_misalign     = 1'b0;
    c_halt         = 1'b0;
    c_reg_wrt      = 1'b0;
    c_err          = 1'b0;
    c_write_reg    = '0;
    c_src_val      = '0;
    c_load_val     = '0;

    case (state_q)
      IDLE: begin
        if (in_valid && !rst) begin
          c_wr        = in_mem_wr;
          c_byte      = in_byte;
          c_byte_hi   = in_alu_out[0];
          c_src_zero  = (in_wrt_src == 3'd0);
          c_src_err   = src_err;
          c_halt      = in_halt;
          c_reg_wrt   = in_reg_wrt;
          c_write_reg = in_write_reg;
          c_src_val   = fwd_data;
          c_misalign  = in_mem_en & ~in_byte & in_alu_out[0];
          if (in_mem_en && !c_misalign) begin
            mem_req   = 1'b1;
            mem_wr    = in_mem_wr;
            mem_byte  = in_byte;
            mem_addr  = in_alu_out[ADDR_W-1:0];
            mem_wdata = in_byte ? byte_wdata : in_reg2;
            if (mem_done) begin
              complete = 1'b1;
              c_mem    = 1'b1;
            end else begin
              stall_out     = 1'b1;
              state_d       = BUSY;
              p_wr_d        = in_mem_wr;
              p_byte_d      = in_byte;
              p_byte_hi_d   = in_alu_out[0];
              p_src_zero_d  = c_src_zero;
              p_src_err_d   = src_err;
              p_halt_d      = in_halt;
              p_reg_wrt_d   = in_reg_wrt;
              p_write_reg_d = in_write_reg;
              p_addr_d      = in_alu_out[ADDR_W-1:0];
              p_wdata_d     = mem_wdata;
              p_src_val_d   = fwd_data;
            end
          end else begin
            complete = 1'b1;
          end
        end
      end
      BUSY: begin
        mem_req     = 1'b1;
        mem_wr      = p_wr_q;
        mem_byte    = p_byte_q;
        mem_addr    = p_addr_q;
        mem_wdata   = p_wdata_q;
        stall_out   = 1'b1;
        c_wr        = p_wr_q;
        c_byte      = p_byte_q;
        c_byte_hi   = p_byte_hi_q;
        c_src_zero  = p_src_zero_q;
        c_src_err   = p_src_err_q;
        c_halt      = p_halt_q;
        c_reg_wrt   = p_reg_wrt_q;
        c_write_reg = p_write_reg_q;
        c_src_val   = p_src_val_q;
        if (mem_done) begin
          complete = 1'b1;
          c_mem    = 1'b1;
          state_d  = IDLE;
        end
      end
      default: ;
    endcase

    if (complete) begin
      c_err = c_src_err | c_misalign | (c_mem & mem_err);
      if (c_byte) c_load_val = {{(DATA_W-8){1'b0}}, (c_byte_hi ? mem_rdata[15:8] : mem_rdata[7:0])};
      else        c_load_val = mem_rdata;
      wb_valid_d     = 1'b1;
      wb_reg_wrt_d   = c_reg_wrt & ~c_err & ~(c_mem & c_wr);
      wb_write_reg_d = c_write_reg;
      wb_data_d      = (c_mem && !c_wr && c_src_zero) ? c_load_val : c_src_val;
      wb_err_d       = c_err;
      wb_halt_d      = c_halt;
      if (c_halt || c_err) begin
        mem_dump_d = 1'b1;
        state_d    = HALTED;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      p_wr_q         <= 1'b0;
      p_byte_q       <= 1'b0;
      p_byte_hi_q    <= 1'b0;
      p_src_zero_q   <= 1'b0;
      p_src_err_q    <= 1'b0;
      p_halt_q       <= 1'b0;
      p_reg_wrt_q    <= 1'b0;
      p_write_reg_q  <= '0;
      p_addr_q       <= '0;
      p_wdata_q      <= '0;
      p_src_val_q    <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_wrt_q   <= 1'b0;
      wb_write_reg_q <= '0;
      wb_data_q      <= '0;
      wb_err_q       <= 1'b0;
      wb_halt_q      <= 1'b0;
      mem_dump_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      p_wr_q         <= p_wr_d;
      p_byte_q       <= p_byte_d;
      p_byte_hi_q    <= p_byte_hi_d;
      p_src_zero_q   <= p_src_zero_d;
      p_src_err_q    <= p_src_err_d;
      p_halt_q       <= p_halt_d;
      p_reg_wrt_q    <= p_reg_wrt_d;
      p_write_reg_q  <= p_write_reg_d;
      p_addr_q       <= p_addr_d;
      p_wdata_q      <= p_wdata_d;
      p_src_val_q    <= p_src_val_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_wrt_q   <= wb_reg_wrt_d;
      wb_write_reg_q <= wb_write_reg_d;
      wb_data_q      <= wb_data_d;
      wb_err_q       <= wb_err_d;
      wb_halt_q      <= wb_halt_d;
      mem_dump_q     <= mem_dump_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_reg_wrt   = wb_reg_wrt_q;
  assign wb_write_reg = wb_write_reg_q;
  assign wb_data      = wb_data_q;
  assign wb_err       = wb_err_q;
  assign wb_halt      = wb_halt_q;
  assign mem_dump     = mem_dump_q;

endmodule

// File: tb/tb_mem_stage_mc.sv
// Directed bench for mem_stage_mc: inputs change and outputs are sampled around the falling edge.
module tb_mem_stage_mc;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int REG_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_mem_en, in_mem_wr, in_byte, in_halt, in_reg_wrt;
  logic [2:0]        in_wrt_src;
  logic [REG_W-1:0]  in_write_reg;
  logic [DATA_W-1:0] in_alu_out, in_set_val, in_reg1, in_reg2, in_next_pc, in_instr;
  logic [DATA_W-1:0] fwd_data, mem_wdata, mem_rdata, wb_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              stall_out, mem_req, mem_wr, mem_byte, mem_done, mem_err, mem_dump;
  logic              wb_valid, wb_reg_wrt, wb_err, wb_halt;
  logic [REG_W-1:0]  wb_write_reg;

  int n_cmp = 0;
  int n_bad = 0;

  mem_stage_mc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_mem_en(in_mem_en), .in_mem_wr(in_mem_wr), .in_byte(in_byte),
    .in_halt(in_halt), .in_reg_wrt(in_reg_wrt), .in_wrt_src(in_wrt_src),
    .in_write_reg(in_write_reg), .in_alu_out(in_alu_out), .in_set_val(in_set_val),
    .in_reg1(in_reg1), .in_reg2(in_reg2), .in_next_pc(in_next_pc), .in_instr(in_instr),
    .fwd_data(fwd_data), .stall_out(stall_out), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_byte(mem_byte), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_err(mem_err), .mem_dump(mem_dump),
    .wb_valid(wb_valid), .wb_reg_wrt(wb_reg_wrt), .wb_write_reg(wb_write_reg),
    .wb_data(wb_data), .wb_err(wb_err), .wb_halt(wb_halt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    in_valid = 0; in_mem_en = 0; in_mem_wr = 0; in_byte = 0; in_halt = 0; in_reg_wrt = 0;
    in_wrt_src = 0; in_write_reg = 0; in_alu_out = 0; in_set_val = 0; in_reg1 = 0;
    in_reg2 = 0; in_next_pc = 0; in_instr = 0; mem_done = 0; mem_rdata = 0; mem_err = 0;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic do_reset();
    next(); clear_in(); rst = 1;
    next(); rst = 0;
  endtask

  logic [2:0]  fw_src [6] = '{3'd4, 3'd6, 3'd2, 3'd3, 3'd0, 3'd7};
  logic [15:0] fw_exp [6] = '{16'hFF80, 16'h8000, 16'h0042, 16'h5A5A, 16'h0000, 16'h0000};

  initial begin
    clear_in();
    rst = 1;
    next(); next();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_dump", mem_dump, 0);
    rst = 0;

    // non-memory op, source 5
    next();
    in_valid = 1; in_wrt_src = 5; in_reg1 = 16'h00AB; in_instr = 16'h12CD;
    in_reg_wrt = 1; in_write_reg = 3;
    #1 chk("nm_fwd", fwd_data, 16'hABCD);
    chk("nm_stall", stall_out, 0);
    chk("nm_req", mem_req, 0);
    next(); clear_in();
    chk("nm_wb_valid", wb_valid, 1);
    chk("nm_wb_data", wb_data, 16'hABCD);
    chk("nm_wb_wrt", wb_reg_wrt, 1);
    chk("nm_wb_reg", wb_write_reg, 3);
    chk("nm_stall2", stall_out, 0);
    next();
    chk("nm_bubble_valid", wb_valid, 0);
    chk("nm_hold_data", wb_data, 16'hABCD);

    // remaining forwarding sources, no instruction accepted
    in_instr = 16'h0080; in_reg1 = 16'h0001; in_next_pc = 16'h0042; in_set_val = 16'h5A5A;
    for (int i = 0; i < 6; i++) begin
      in_wrt_src = fw_src[i];
      #1 chk($sformatf("fwd_src%0d", fw_src[i]), fwd_data, fw_exp[i]);
    end
    clear_in();

    // word load, done in third cycle
    next();
    in_valid = 1; in_mem_en = 1; in_alu_out = 16'h0010; in_reg_wrt = 1; in_write_reg = 5;
    #1 chk("wl_c1_req", mem_req, 1);
    chk("wl_c1_stall", stall_out, 1);
    chk("wl_c1_addr", mem_addr, 16'h0010);
    chk("wl_c1_wr", mem_wr, 0);
    next(); in_valid = 0; in_alu_out = 16'h5555;
    #1 chk("wl_c2_req", mem_req, 1);
    chk("wl_c2_stall", stall_out, 1);
    chk("wl_c2_addr", mem_addr, 16'h0010);
    chk("wl_c2_valid", wb_valid, 0);
    next(); mem_done = 1; mem_rdata = 16'h1234;
    #1 chk("wl_c3_req", mem_req, 1);
    chk("wl_c3_stall", stall_out, 1);
    next(); clear_in();
    #1 chk("wl_c4_valid", wb_valid, 1);
    chk("wl_c4_data", wb_data, 16'h1234);
    chk("wl_c4_wrt", wb_reg_wrt, 1);
    chk("wl_c4_reg", wb_write_reg, 5);
    chk("wl_c4_req", mem_req, 0);
    chk("wl_c4_stall", stall_out, 0);

    // zero-wait byte loads, high then low lane
    next();
    in_valid = 1; in_mem_en = 1; in_byte = 1; in_alu_out = 16'h0021; in_reg_wrt = 1;
    mem_done = 1; mem_rdata = 16'hBEEF;
    #1 chk("bl_req", mem_req, 1);
    chk("bl_byte", mem_byte, 1);
    chk("bl_stall", stall_out, 0);
    chk("bl_addr", mem_addr, 16'h0021);
    in_alu_out = 16'h0021;
    next();
    chk("bl_hi_data", wb_data, 16'h00BE);
    chk("bl_hi_valid", wb_valid, 1);
    in_alu_out = 16'h0020;
    next();
    chk("bl_lo_data", wb_data, 16'h00EF);
    clear_in();

    // zero-wait byte store
    in_valid = 1; in_mem_en = 1; in_mem_wr = 1; in_byte = 1; in_alu_out = 16'h0030;
    in_reg2 = 16'h1177; in_reg_wrt = 1; in_wrt_src = 1; mem_done = 1;
    #1 chk("bs_wdata", mem_wdata, 16'h7777);
    chk("bs_byte", mem_byte, 1);
    chk("bs_wr", mem_wr, 1);
    next(); clear_in();
    chk("bs_valid", wb_valid, 1);
    chk("bs_wrt", wb_reg_wrt, 0);
    chk("bs_data", wb_data, 16'h0030);

    // word store with latency: wdata is reg2
    next();
    in_valid = 1; in_mem_en = 1; in_mem_wr = 1; in_alu_out = 16'h0044; in_reg2 = 16'hC3A5;
    #1 chk("ws_wdata", mem_wdata, 16'hC3A5);
    next(); in_valid = 0; in_reg2 = 16'h0000;
    #1 chk("ws_wdata_held", mem_wdata, 16'hC3A5);
    chk("ws_wr_held", mem_wr, 1);
    mem_done = 1;
    next(); clear_in();
    chk("ws_valid", wb_valid, 1);
    chk("ws_wrt", wb_reg_wrt, 0);

    // reset mid-BUSY
    next();
    in_valid = 1; in_mem_en = 1; in_alu_out = 16'h0040; in_reg_wrt = 1;
    next(); in_valid = 0;
    #1 chk("rb_req_before", mem_req, 1);
    rst = 1;
    #1 chk("rb_req", mem_req, 0);
    chk("rb_stall", stall_out, 0);
    chk("rb_valid", wb_valid, 0);
    chk("rb_data", wb_data, 0);
    next(); rst = 0; clear_in();
    next(); mem_done = 1; mem_rdata = 16'h9999;
    #1 chk("rb_late_req", mem_req, 0);
    next(); mem_done = 0;
    chk("rb_late_valid", wb_valid, 0);
    chk("rb_late_data", wb_data, 0);

    // misaligned word store
    next();
    in_valid = 1; in_mem_en = 1; in_mem_wr = 1; in_alu_out = 16'h0003; in_reg_wrt = 1; in_wrt_src = 1;
    #1 chk("ma_req", mem_req, 0);
    chk("ma_stall", stall_out, 0);
    next(); clear_in();
    chk("ma_valid", wb_valid, 1);
    chk("ma_err", wb_err, 1);
    chk("ma_wrt", wb_reg_wrt, 0);
    chk("ma_dump", mem_dump, 1);
    in_valid = 1; in_mem_en = 1; in_alu_out = 16'h0010; in_reg_wrt = 1;
    #1 chk("hz_req", mem_req, 0);
    chk("hz_stall", stall_out, 0);
    next();
    chk("hz_dump", mem_dump, 0);
    chk("hz_valid", wb_valid, 0);
    next();
    chk("hz_valid2", wb_valid, 0);

    // halt instruction
    do_reset();
    in_valid = 1; in_halt = 1; in_wrt_src = 1; in_alu_out = 16'h0077; in_reg_wrt = 1;
    next(); clear_in(); in_valid = 1; in_wrt_src = 1; in_reg_wrt = 1;
    chk("h_valid", wb_valid, 1);
    chk("h_halt", wb_halt, 1);
    chk("h_dump", mem_dump, 1);
    chk("h_err", wb_err, 0);
    chk("h_data", wb_data, 16'h0077);
    next();
    chk("h_dump_off", mem_dump, 0);
    chk("h_no_valid", wb_valid, 0);
    next();
    chk("h_no_valid2", wb_valid, 0);

    // illegal write source
    do_reset();
    in_valid = 1; in_wrt_src = 7; in_reg_wrt = 1; in_alu_out = 16'h1111;
    next(); clear_in();
    chk("is_valid", wb_valid, 1);
    chk("is_err", wb_err, 1);
    chk("is_wrt", wb_reg_wrt, 0);
    chk("is_dump", mem_dump, 1);
    chk("is_data", wb_data, 0);
    chk("is_halt", wb_halt, 0);

    // memory error on a zero-wait load
    do_reset();
    in_valid = 1; in_mem_en = 1; in_alu_out = 16'h0010; in_reg_wrt = 1;
    mem_done = 1; mem_err = 1; mem_rdata = 16'h4321;
    next(); clear_in();
    chk("me_err", wb_err, 1);
    chk("me_wrt", wb_reg_wrt, 0);
    chk("me_dump", mem_dump, 1);

    next();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
